// File: rtl/serving_mem_sched.sv
// serving_mem_sched
//   Registered round-robin scheduler sharing the single-port serving RAM
//   Wishbone port between the SERV instruction bus (read-only) and the data
//   bus. A bounded-wait watchdog forces completion if the memory never acks,
//   and it sets a sticky error flag when it does so.
//
//   Ports
//     i_clk, i_rst_n          clock, asynchronous active-low reset
//     i_ibus_adr/stb          instruction fetch request (held until ack)
//     o_ibus_ack              one-cycle ibus completion pulse
//     i_dbus_adr/dat/sel/we   data request fields
//     i_dbus_stb              data request (held until ack)
//     o_dbus_ack              one-cycle dbus completion pulse
//     o_cpu_rdt               read data, valid alongside either ack
//     o_mem_adr/dat/sel/we    registered memory request fields
//     o_mem_stb               memory strobe, high only while in MEM
//     i_mem_rdt, i_mem_ack    memory response
//     o_err                   sticky: a watchdog timeout occurred since reset
module serving_mem_sched #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [AW-1:0] i_ibus_adr,
    input  logic          i_ibus_stb,
    output logic          o_ibus_ack,
    input  logic [AW-1:0] i_dbus_adr,
    input  logic [31:0]   i_dbus_dat,
    input  logic [3:0]    i_dbus_sel,
    input  logic          i_dbus_we,
    input  logic          i_dbus_stb,
    output logic          o_dbus_ack,
    output logic [31:0]   o_cpu_rdt,
    output logic [AW-1:0] o_mem_adr,
    output logic [31:0]   o_mem_dat,
    output logic [3:0]    o_mem_sel,
    output logic          o_mem_we,
    output logic          o_mem_stb,
    input  logic [31:0]   i_mem_rdt,
    input  logic          i_mem_ack,
    output logic          o_err
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_dbus_q;   // 1 when dbus won the most recent grant
    logic        gnt_dbus_q;    // master owning the current transfer
    logic [7:0]  wait_cnt_q;
    logic [7:0]  wait_nxt;

    logic        grant;
    logic        grant_dbus;
    logic        mem_done;
    logic        timeout;

    assign wait_nxt = wait_cnt_q + 8'd1;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        grant      = 1'b0;
        grant_dbus = 1'b0;
        mem_done   = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_ibus_stb || i_dbus_stb) begin
                    grant      = 1'b1;
                    // Under contention the master that lost last time wins.
                    grant_dbus = i_dbus_stb && (!i_ibus_stb || !last_dbus_q);
                    state_d    = MEM;
                end
            end
            MEM: begin
                // An ack arriving on the final allowed cycle beats the watchdog.
                if (i_mem_ack) begin
                    mem_done = 1'b1;
                    state_d  = RESP;
                end else if (wait_nxt == TIMEOUT_CNT) begin
                    timeout = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;  // no grant here: lets the master drop stb
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_dbus_q <= 1'b1;   // ibus wins the first tie after reset
            gnt_dbus_q  <= 1'b0;
            wait_cnt_q  <= 8'd0;
            o_mem_adr   <= '0;
            o_mem_dat   <= 32'd0;
            o_mem_sel   <= 4'd0;
            o_mem_we    <= 1'b0;
            o_cpu_rdt   <= 32'd0;
            o_err       <= 1'b0;
        end else begin
            if (grant) begin
                wait_cnt_q  <= 8'd0;
                gnt_dbus_q  <= grant_dbus;
                last_dbus_q <= grant_dbus;
                if (grant_dbus) begin
                    o_mem_adr <= i_dbus_adr;
                    o_mem_dat <= i_dbus_dat;
                    o_mem_sel <= i_dbus_sel;
                    o_mem_we  <= i_dbus_we;
                end else begin
                    o_mem_adr <= i_ibus_adr;
                    o_mem_dat <= 32'd0;
                    o_mem_sel <= 4'hf;
                    o_mem_we  <= 1'b0;
                end
            end else if (state_q == MEM) begin
                wait_cnt_q <= wait_nxt;
            end

            if (mem_done) begin
                o_cpu_rdt <= i_mem_rdt;
            end else if (timeout) begin
                o_cpu_rdt <= 32'd0;
                o_err     <= 1'b1;
            end
        end
    end

    // Decoded straight from state flops so an async reset drops the strobe
    // and suppresses the ack pulse without waiting for a clock edge.
    assign o_mem_stb  = (state_q == MEM);
    assign o_ibus_ack = (state_q == RESP) && !gnt_dbus_q;
    assign o_dbus_ack = (state_q == RESP) &&  gnt_dbus_q;

endmodule
